reg_dump_scanner: RTL and testbench
===================================

# reg_dump_scanner

Sequential reader for the register file's debug read port (`reg_sel`/`reg_data`). It walks either all registers or a single selected register, capturing each value, and streams it out as an (index, data) word over a valid/ready handshake. The consumer is a UART or display formatter. It sits beside the multi-cycle CPU. It is triggered by a start pulse or an optional free-running refresh timer. It never touches the CPU's write path.

## Interface
Parameters:
- `NUM_REGS`, 32, number of registers scanned in full mode.
- `SEL_W`, 5, width of the register index.
- `DATA_W`, 32, register data width.
- `REFRESH_CYCLES`, 0, auto-start period in clk cycles; 0 disables auto-refresh.

Ports (reset `rst` is asynchronous and active-high; clock is `clk`):
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous active-high reset.
- `start`  in  1  one-cycle request to begin a dump; honoured only in IDLE.
- `single`  in  1  sampled with `start`: 1 dumps only `start_sel`; 0 dumps indices 0..NUM_REGS-1.
- `start_sel`  in  SEL_W  register index for single mode, sampled with `start`.
- `reg_sel`  out  SEL_W  registered index presented to the register file debug port.
- `reg_data`  in  DATA_W  combinational register file response to `reg_sel`.
- `out_valid`  out  1  output word available.
- `out_ready`  in  1  consumer accepts the word when `out_valid && out_ready`.
- `out_idx`  out  SEL_W  index of the word.
- `out_data`  out  DATA_W  captured register value.
- `out_last`  out  1  word is the final one of the dump.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the last word is accepted.

## Operation
- FSM states: IDLE, LOAD, SEND, DONE.
- IDLE:
  - On `start`, latch the mode.
  - Set `reg_sel` to `start_sel` in single mode, or 0 in full mode.
  - Go to LOAD.
- LOAD (1 cycle):
  - `reg_sel` has been stable since the previous edge.
  - Capture `reg_data` into `out_data` and `reg_sel` into `out_idx`.
  - Set `out_last` = single mode, or `reg_sel == NUM_REGS-1`.
  - Assert `out_valid` and go to SEND.
- SEND:
  - Hold `out_valid`, `out_idx`, `out_data` and `out_last` stable until the handshake.
  - On handshake, deassert `out_valid`.
  - If `out_last`, go to DONE.
  - Otherwise set `reg_sel` to `reg_sel+1` and go to LOAD.
- DONE (1 cycle): pulse `done`, then return to IDLE. `reg_sel` holds its last value.
- Index 0 reads 0 via the register file's hard-wired zero. The scanner does not special-case it.
- Auto-refresh (`REFRESH_CYCLES` > 0):
  - The counter runs only in IDLE and clears on entering IDLE or on `start`.
  - When the counter reaches `REFRESH_CYCLES-1`, it self-starts using the most recently latched `single`/`start_sel`. After reset these are full mode and index 0.
- `start` is ignored while `busy`. No queueing.
- No snapshot atomicity: each register is sampled at its own LOAD cycle. Writes by the CPU during a dump are visible to later indices.
- Reset mid-dump: all state clears immediately. No `done` pulse. A word in flight is dropped.

## Timing
- Reset values:
  - `reg_sel` 0, `out_valid` 0, `out_idx` 0, `out_data` 0, `out_last` 0, `busy` 0, `done` 0.
  - FSM in IDLE, refresh counter 0, latched mode full/0.
- Latency from `start` at edge N:
  - `busy` high after edge N.
  - `out_valid` high after edge N+1 (LOAD at edge N+1).
- Throughput: 2 cycles per word with `out_ready` held high.
- Full dump: `start` to `done`-high is 2*NUM_REGS+1 edges (65 for 32 registers) with `out_ready` held high.
- Back-pressure adds one cycle per stalled cycle. `out_*` must not change while `out_valid && !out_ready`.
- `out_ready` high before `out_valid` is legal. The handshake completes in the first SEND cycle.
- `done` and `busy` are both high in the DONE cycle. `busy` drops the cycle after.
- `start` in the same cycle as the DONE→IDLE transition is ignored. `start` on the first IDLE cycle is accepted.

## Structure
- Package `reg_dump_pkg`:
  - FSM state enum (IDLE, LOAD, SEND, DONE).
  - Default `NUM_REGS`, `SEL_W` and `DATA_W` constants.
- Sub-module `dump_refresh_timer`:
  - Cycle counter with a clear input and a terminal-count pulse.
  - Tied off when `REFRESH_CYCLES` = 0.
- The scanner instantiates alongside the register file. Its `reg_sel`/`reg_data` connect directly to the debug port.

## Test plan
- Preload r1..r31 = 0x1000_0000+i, full-mode `start`, `out_ready`=1 → 32 words: idx 0 data 0x0, then idx i data 0x1000_0000+i. `out_last` only on idx 31. `done` 65 edges after `start`.
- Single mode, `start_sel`=7, r7=0xDEAD_BEEF → exactly one word idx 7 data 0xDEAD_BEEF with `out_last`=1, then `done`. `reg_sel` stays 7.
- `out_ready` toggled 1 cycle in 3 during a full dump → all `out_*` stable while stalled, 32 words in order, no loss or duplication.
- `start` pulsed mid-dump at idx 10 → ignored. Sequence continues to idx 31 with a single `done`.
- `rst` asserted in SEND at idx 5 → `out_valid`, `busy` and `reg_sel` go to 0 immediately, no `done`. A new `start` gives a full dump from idx 0.
- `REFRESH_CYCLES`=100, single r3 latched by one `start` → after each `done`, an automatic dump of idx 3 begins 100 cycles after return to IDLE. CPU write r3=0x55 between dumps is reflected in the next word.

Source files
------------

// File: rtl/reg_dump_pkg.sv
// Shared types and default sizes for the register dump scanner.
// The defaults match a 32 x 32-bit register file with a 5-bit debug index.
package reg_dump_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        DONE
    } dump_state_t;

    localparam int DEFAULT_NUM_REGS = 32;
    localparam int DEFAULT_SEL_W    = 5;
    localparam int DEFAULT_DATA_W   = 32;

endpackage

// File: rtl/dump_refresh_timer.sv
// Idle-time counter that emits a one-cycle tick every CYCLES enabled cycles.
// When CYCLES is 0 the tick is tied low and the counter stays at zero.
module dump_refresh_timer #(
    parameter int CYCLES = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'((CYCLES > 0) ? CYCLES - 1 : 0);
    localparam logic ENABLED = (CYCLES > 0);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || (enable && count == LAST)) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign tick = ENABLED && enable && (count == LAST);

endmodule

// File: rtl/reg_dump_scanner.sv
// Walks the register file debug port and streams (index, data) words over valid/ready.
// Dumps every register or one selected register, on a start pulse or a refresh timer.
module reg_dump_scanner
    import reg_dump_pkg::*;
#(
    parameter int NUM_REGS       = DEFAULT_NUM_REGS,
    parameter int SEL_W          = DEFAULT_SEL_W,
    parameter int DATA_W         = DEFAULT_DATA_W,
    parameter int REFRESH_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              single,
    input  logic [SEL_W-1:0]  start_sel,
    output logic [SEL_W-1:0]  reg_sel,
    input  logic [DATA_W-1:0] reg_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SEL_W-1:0]  out_idx,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_REGS - 1);

    dump_state_t      state;
    dump_state_t      state_next;
    logic             mode_single;
    logic [SEL_W-1:0] mode_sel;
    logic             refresh_tick;
    logic             launch;
    logic             handshake;

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign out_valid = (state == SEND);
    assign launch    = (state == IDLE) && (start || refresh_tick);
    assign handshake = (state == SEND) && out_ready;

    // Counts only while idle; any start restarts the refresh period.
    dump_refresh_timer #(
        .CYCLES (REFRESH_CYCLES)
    ) u_refresh_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (busy || start),
        .enable (!busy),
        .tick   (refresh_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (launch) state_next = LOAD;
            LOAD: state_next = SEND;
            SEND: if (handshake) state_next = out_last ? DONE : LOAD;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // An explicit start replaces the remembered mode; a refresh tick reuses it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_single <= 1'b0;
            mode_sel    <= '0;
            reg_sel     <= '0;
            out_idx     <= '0;
            out_data    <= '0;
            out_last    <= 1'b0;
        end else begin
            if (launch) begin
                if (start) begin
                    mode_single <= single;
                    mode_sel    <= start_sel;
                    reg_sel     <= single ? start_sel : '0;
                end else begin
                    reg_sel <= mode_single ? mode_sel : '0;
                end
            end
            if (state == LOAD) begin
                out_idx  <= reg_sel;
                out_data <= reg_data;
                out_last <= mode_single || (reg_sel == LAST_IDX);
            end
            if (handshake && !out_last) begin
                reg_sel <= reg_sel + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reg_dump_scanner.sv
// Bench for reg_dump_scanner: scoreboard of expected words plus directed timing checks.
// A second instance with a 100-cycle refresh period covers the auto-start path.
module tb_reg_dump_scanner;
    import reg_dump_pkg::*;

    localparam int NR = 32;
    localparam int SW = 5;
    localparam int DW = 32;

    typedef struct {
        logic [SW-1:0] idx;
        logic [DW-1:0] data;
        logic          last;
    } word_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] regs [NR];

    logic          rst, start, single, out_ready;
    logic [SW-1:0] start_sel, reg_sel, out_idx;
    logic [DW-1:0] reg_data, out_data;
    logic          out_valid, out_last, busy, done;

    logic          rst_r, start_r, single_r, out_ready_r;
    logic [SW-1:0] start_sel_r, reg_sel_r, out_idx_r;
    logic [DW-1:0] reg_data_r, out_data_r;
    logic          out_valid_r, out_last_r, busy_r, done_r;

    assign reg_data   = regs[reg_sel];
    assign reg_data_r = regs[reg_sel_r];

    reg_dump_scanner #(.NUM_REGS(NR), .SEL_W(SW), .DATA_W(DW), .REFRESH_CYCLES(0)) dut (
        .clk(clk), .rst(rst), .start(start), .single(single), .start_sel(start_sel),
        .reg_sel(reg_sel), .reg_data(reg_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx), .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
    );

    reg_dump_scanner #(.NUM_REGS(NR), .SEL_W(SW), .DATA_W(DW), .REFRESH_CYCLES(100)) dut_r (
        .clk(clk), .rst(rst_r), .start(start_r), .single(single_r), .start_sel(start_sel_r),
        .reg_sel(reg_sel_r), .reg_data(reg_data_r), .out_valid(out_valid_r), .out_ready(out_ready_r),
        .out_idx(out_idx_r), .out_data(out_data_r), .out_last(out_last_r), .busy(busy_r), .done(done_r)
    );

    int    errors = 0;
    int    checks = 0;
    int    words = 0;
    int    done_cnt = 0;
    int    done_edge = 0;
    word_t exp_q[$];

    logic          stall_prev = 1'b0;
    logic [SW-1:0] prev_idx;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every accepted word must be the next one the model predicts; stalled words must hold.
    always @(negedge clk) begin
        word_t w;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checkOutput("stall_hold", 64'({out_valid, out_idx, out_data, out_last}),
                            64'({1'b1, prev_idx, prev_data, prev_last}));
            end
            if (done) done_cnt++;
            if (out_valid && out_ready) begin
                checkOutput("word_expected", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                    w = exp_q.pop_front();
                    checkOutput("word_idx", 64'(out_idx), 64'(w.idx));
                    checkOutput("word_data", 64'(out_data), 64'(w.data));
                    checkOutput("word_last", 64'(out_last), 64'(w.last));
                    words++;
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_idx   = out_idx;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    // pattern 0: out_ready always high; 1: high one cycle in three.
    // inject_at / reset_at >= 0 pulse start / assert rst while that index is on offer.
    task automatic applyStimulus(input logic sgl, input logic [SW-1:0] sel, input int pattern,
                                 input int inject_at, input int reset_at);
        int k;
        bit fin;
        bit injected;
        word_t w;
        exp_q.delete();
        words     = 0;
        done_cnt  = 0;
        done_edge = 0;
        if (sgl) begin
            w.idx = sel; w.data = (sel == 0) ? '0 : regs[sel]; w.last = 1'b1;
            exp_q.push_back(w);
        end else begin
            for (int i = 0; i < NR; i++) begin
                w.idx = SW'(i); w.data = (i == 0) ? '0 : regs[i]; w.last = (i == NR - 1);
                exp_q.push_back(w);
            end
        end
        single = sgl; start_sel = sel; start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        k = 1; fin = 0; injected = 0;
        checkOutput("busy_after_start", 64'(busy), 64'(1));
        while (!fin && k < 2000) begin
            if (done) begin
                done_edge = k;
                fin = 1;
            end else if (reset_at >= 0 && out_valid && out_idx == SW'(reset_at)) begin
                #1 rst = 1'b1;
                #1;
                checkOutput("rst_valid", 64'(out_valid), 64'(0));
                checkOutput("rst_busy", 64'(busy), 64'(0));
                checkOutput("rst_reg_sel", 64'(reg_sel), 64'(0));
                checkOutput("rst_done", 64'(done), 64'(0));
                exp_q.delete();
                @(posedge clk); @(posedge clk); #1 rst = 1'b0;
                fin = 1;
            end else begin
                out_ready = (pattern == 1) ? (k % 3 == 0) : 1'b1;
                if (inject_at >= 0 && !injected && out_valid && out_idx == SW'(inject_at)) begin
                    start = 1'b1; single = 1'b1; start_sel = 5'd3; injected = 1;
                end
                @(posedge clk); #1; start = 1'b0;
                k++;
            end
        end
        if (reset_at < 0) begin
            checkOutput("done_seen", 64'(done_edge != 0), 64'(1));
            single = 1'b0; start_sel = '0; start = 1'b1;
            @(posedge clk); #1; start = 1'b0;
            checkOutput("idle_after_done", 64'(busy), 64'(0));
            checkOutput("done_one_cycle", 64'(done), 64'(0));
            checkOutput("all_words_seen", 64'(exp_q.size()), 64'(0));
        end
    endtask

    initial begin
        int t;
        logic [DW-1:0] exp_r3;
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t;
        logic [DW-1:0] exp_r3;
        rst = 1'b1; start = 1'b0; single = 1'b0; start_sel = '0; out_ready = 1'b1;
        rst_r = 1'b1; start_r = 1'b0; single_r = 1'b0; start_sel_r = '0; out_ready_r = 1'b1;
        for (int i = 0; i < NR; i++) regs[i] = (i == 0) ? '0 : 32'h1000_0000 + 32'(i);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("reset_reg_sel", 64'(reg_sel), 64'(0));
        checkOutput("reset_valid", 64'(out_valid), 64'(0));
        checkOutput("reset_idx", 64'(out_idx), 64'(0));
        checkOutput("reset_data", 64'(out_data), 64'(0));
        checkOutput("reset_last", 64'(out_last), 64'(0));
        checkOutput("reset_busy", 64'(busy), 64'(0));
        checkOutput("reset_done", 64'(done), 64'(0));

        $display("[TB] full dump, ready high");
        applyStimulus(1'b0, 5'd0, 0, -1, -1);
        checkOutput("full_done_edge", 64'(done_edge), 64'(65));
        checkOutput("full_words", 64'(words), 64'(32));
        checkOutput("full_done_count", 64'(done_cnt), 64'(1));
        checkOutput("full_final_idx", 64'(out_idx), 64'(31));
        checkOutput("full_final_data", 64'(out_data), 64'h1000_001F);

        $display("[TB] single dump of r7");
        regs[7] = 32'hDEAD_BEEF;
        applyStimulus(1'b1, 5'd7, 0, -1, -1);
        checkOutput("single_done_edge", 64'(done_edge), 64'(3));
        checkOutput("single_words", 64'(words), 64'(1));
        checkOutput("single_data", 64'(out_data), 64'hDEAD_BEEF);
        checkOutput("single_last", 64'(out_last), 64'(1));
        repeat (3) @(posedge clk);
        #1 checkOutput("single_reg_sel_hold", 64'(reg_sel), 64'(7));

        $display("[TB] full dump with back-pressure");
        applyStimulus(1'b0, 5'd0, 1, -1, -1);
        checkOutput("stall_words", 64'(words), 64'(32));
        checkOutput("stall_done_count", 64'(done_cnt), 64'(1));

        $display("[TB] start pulsed mid-dump");
        applyStimulus(1'b0, 5'd0, 0, 10, -1);
        checkOutput("inject_done_edge", 64'(done_edge), 64'(65));
        checkOutput("inject_words", 64'(words), 64'(32));
        checkOutput("inject_done_count", 64'(done_cnt), 64'(1));

        $display("[TB] reset during SEND of idx 5");
        applyStimulus(1'b0, 5'd0, 0, -1, 5);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_words", 64'(words), 64'(5));
        checkOutput("rst_no_done", 64'(done_cnt), 64'(0));
        checkOutput("rst_idle", 64'(busy), 64'(0));
        applyStimulus(1'b0, 5'd0, 0, -1, -1);
        checkOutput("post_rst_done_edge", 64'(done_edge), 64'(65));
        checkOutput("post_rst_words", 64'(words), 64'(32));

        $display("[TB] auto-refresh of r3");
        @(posedge clk); #1 rst_r = 1'b0;
        @(posedge clk); #1;
        regs[3] = 32'h0000_0033;
        start_r = 1'b1; single_r = 1'b1; start_sel_r = 5'd3;
        @(posedge clk); #1 start_r = 1'b0; single_r = 1'b0; start_sel_r = '0;
        checkOutput("r_busy_after_start", 64'(busy_r), 64'(1));
        for (int n = 0; n < 3; n++) begin
            exp_r3 = (n == 0) ? 32'h33 : (n == 1) ? 32'h55 : 32'h66;
            if (n > 0) begin
                t = 0;
                do begin
                    @(posedge clk); #1; t++;
                end while (!busy_r && t < 300);
                checkOutput("r_refresh_period", 64'(t), 64'(101));
            end
            t = 0;
            while (!out_valid_r && t < 10) begin
                @(posedge clk); #1; t++;
            end
            checkOutput("r_valid_seen", 64'(out_valid_r), 64'(1));
            checkOutput("r_idx", 64'(out_idx_r), 64'(3));
            checkOutput("r_data", 64'(out_data_r), 64'(exp_r3));
            checkOutput("r_last", 64'(out_last_r), 64'(1));
            t = 0;
            while (!done_r && t < 10) begin
                @(posedge clk); #1; t++;
            end
            checkOutput("r_done_seen", 64'(done_r), 64'(1));
            regs[3] = (n == 0) ? 32'h55 : 32'h66;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
